// File: rtl/seg_pkg.sv
//==============================================================================
// Module  : seg_pkg
// Brief   : Shared constants, digit index type and anode decode helper for the
//           multiplexed three-digit common-anode 7-segment display.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package seg_pkg;

    localparam logic [7:0] SEG_OFF  = 8'hFF;
    localparam logic [7:0] SEG_ZERO = 8'hC0;
    localparam logic [2:0] AN_OFF   = 3'b111;

    typedef enum logic [1:0] {
        DIG_U = 2'd0,
        DIG_D = 2'd1,
        DIG_C = 2'd2
    } digit_idx_t;

    // Active-low one-cold anode pattern for a digit; unused encoding keeps all off.
    function automatic logic [2:0] an_select(input digit_idx_t d);
        logic [2:0] r;
        case (d)
            DIG_U:   r = 3'b110;
            DIG_D:   r = 3'b101;
            DIG_C:   r = 3'b011;
            default: r = AN_OFF;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seven_seg_scan_timer.sv
//==============================================================================
// Module  : seg_slot_timer
// Brief   : Slot counter and digit sequencer for the display scan. cnt, idx,
//           show and frame_tick describe the slot position that the output
//           registers will hold after the coming edge; load marks that edge as
//           the frame boundary where the pattern shadows must capture.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module seg_slot_timer
    import seg_pkg::*;
#(
    parameter  int DIV   = 50000,
    parameter  int BLANK = 500,
    localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic [CW-1:0] cnt,
    output digit_idx_t    idx,
    output logic          show,
    output logic          frame_tick,
    output logic          load
);

    localparam logic [CW-1:0] c_last_cnt = CW'(DIV - 1);

    logic          r_run;
    logic [CW-1:0] r_cnt;
    digit_idx_t    r_idx;
    logic [CW-1:0] w_cnt_nxt;
    digit_idx_t    w_idx_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run <= 1'b0;
            r_cnt <= '0;
            r_idx <= DIG_U;
        end else begin
            r_run <= 1'b1;
            r_cnt <= w_cnt_nxt;
            r_idx <= w_idx_nxt;
        end
    end

    // The first edge out of reset holds position 0 so the first displayed
    // cycle is slot 0, cycle 0 of a frame and carries the frame tick.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_idx_nxt = r_idx;
        load      = 1'b0;
        if (r_run) begin
            if (r_cnt == c_last_cnt) begin
                w_cnt_nxt = '0;
                load      = (r_idx == DIG_C);
                case (r_idx)
                    DIG_U:   w_idx_nxt = DIG_D;
                    DIG_D:   w_idx_nxt = DIG_C;
                    default: w_idx_nxt = DIG_U;
                endcase
            end else begin
                w_cnt_nxt = r_cnt + CW'(1);
            end
        end
    end

    assign cnt        = w_cnt_nxt;
    assign idx        = w_idx_nxt;
    assign frame_tick = (w_cnt_nxt == '0) && (w_idx_nxt == DIG_U);

    generate
        if (BLANK == 0) begin : g_no_blank
            assign show = 1'b1;
        end else begin : g_blank
            assign show = (w_cnt_nxt >= CW'(BLANK));
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/seven_seg_scan.sv
//==============================================================================
// Module  : seven_seg_scan
// Brief   : Time-multiplexed driver for a three-digit common-anode display with
//           per-slot blanking and frame-coherent pattern snapshots.
//           Optional leading-zero blanking: define SEVEN_SEG_SCAN_LZB_EN.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module seven_seg_scan
    import seg_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] Seg_U,
    input  logic [7:0] Seg_D,
    input  logic [7:0] Seg_C,
    output logic [7:0] seg,
    output logic [2:0] an,
    output logic       frame_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] w_unused_cnt;
    digit_idx_t    w_idx;
    logic          w_show;
    logic          w_tick;
    logic          w_load;

    logic [7:0]    r_sh_u, r_sh_d, r_sh_c;
    logic [7:0]    w_sh_u_nxt, w_sh_d_nxt, w_sh_c_nxt;
    logic [7:0]    w_pat;
    logic [7:0]    r_seg;
    logic [2:0]    r_an;
    logic          r_tick;

    seg_slot_timer #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .cnt        (w_unused_cnt),
        .idx        (w_idx),
        .show       (w_show),
        .frame_tick (w_tick),
        .load       (w_load)
    );

    // Shadows change only on the frame boundary, so a frame never mixes two
    // input snapshots.
    always_comb begin
        w_sh_u_nxt = r_sh_u;
        w_sh_d_nxt = r_sh_d;
        w_sh_c_nxt = r_sh_c;
        if (w_load) begin
            w_sh_u_nxt = Seg_U;
            w_sh_d_nxt = Seg_D;
            w_sh_c_nxt = Seg_C;
        end
    end

`ifdef SEVEN_SEG_SCAN_LZB_EN
    logic w_blank_c;
    logic w_blank_d;

    // Tens may only be suppressed when hundreds already is, so "105" keeps its 0.
    assign w_blank_c = (w_sh_c_nxt == SEG_ZERO);
    assign w_blank_d = w_blank_c && (w_sh_d_nxt == SEG_ZERO);

    always_comb begin
        w_pat = SEG_OFF;
        case (w_idx)
            DIG_U:   w_pat = w_sh_u_nxt;
            DIG_D:   w_pat = w_blank_d ? SEG_OFF : w_sh_d_nxt;
            DIG_C:   w_pat = w_blank_c ? SEG_OFF : w_sh_c_nxt;
            default: w_pat = SEG_OFF;
        endcase
    end
`else
    always_comb begin
        w_pat = SEG_OFF;
        case (w_idx)
            DIG_U:   w_pat = w_sh_u_nxt;
            DIG_D:   w_pat = w_sh_d_nxt;
            DIG_C:   w_pat = w_sh_c_nxt;
            default: w_pat = SEG_OFF;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_u <= SEG_OFF;
            r_sh_d <= SEG_OFF;
            r_sh_c <= SEG_OFF;
            r_seg  <= SEG_OFF;
            r_an   <= AN_OFF;
            r_tick <= 1'b0;
        end else begin
            r_sh_u <= w_sh_u_nxt;
            r_sh_d <= w_sh_d_nxt;
            r_sh_c <= w_sh_c_nxt;
            r_seg  <= w_show ? w_pat : SEG_OFF;
            r_an   <= w_show ? an_select(w_idx) : AN_OFF;
            r_tick <= w_tick;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_tick = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
//==============================================================================
// Module  : tb_seven_seg_scan
// Brief   : Randomised model-checked bench for seven_seg_scan (DIV=8, BLANK=2
//           and a BLANK=0 twin sharing the same inputs and reset).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_seven_seg_scan;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 3 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] su, sd, sc;
    logic [7:0] seg0, seg1;
    logic [2:0] an0, an1;
    logic       tk0, tk1;

    int checks   = 0;
    int failures = 0;

    // t: edges since the last reset edge (-1 before any reset); m_*: snapshot
    // the display must currently be showing.
    int         t = -1;
    logic [7:0] m_u = 8'hFF, m_d = 8'hFF, m_c = 8'hFF;

    always #5 clk = ~clk;

    seven_seg_scan #(.DIV(DIV), .BLANK(BLANK)) dut0 (
        .clk(clk), .rst(rst), .Seg_U(su), .Seg_D(sd), .Seg_C(sc),
        .seg(seg0), .an(an0), .frame_tick(tk0)
    );

    seven_seg_scan #(.DIV(DIV), .BLANK(0)) dut1 (
        .clk(clk), .rst(rst), .Seg_U(su), .Seg_D(sd), .Seg_C(sc),
        .seg(seg1), .an(an1), .frame_tick(tk1)
    );

    always @(posedge clk) begin
        if (rst) begin
            t   = 0;
            m_u = 8'hFF;
            m_d = 8'hFF;
            m_c = 8'hFF;
        end else if (t >= 0) begin
            t = t + 1;
            if (t > 1 && (t - 1) % FRAME == 0) begin
                m_u = su;
                m_d = sd;
                m_c = sc;
            end
        end
    end

    // Expected {frame_tick, an, seg} for display position t-1 since reset.
    function automatic logic [11:0] model(input int tt, input int blank,
                                          input logic [7:0] u, input logic [7:0] d,
                                          input logic [7:0] c);
        int         p, cn, ix;
        logic       tk;
        logic [7:0] pat;
        logic [2:0] a;
        if (tt <= 0) return {1'b0, 3'b111, 8'hFF};
        p  = tt - 1;
        cn = p % DIV;
        ix = (p / DIV) % 3;
        tk = (p % FRAME == 0);
        if (cn < blank) return {tk, 3'b111, 8'hFF};
        pat = (ix == 0) ? u : (ix == 1) ? d : c;
`ifdef SEVEN_SEG_SCAN_LZB_EN
        if (ix == 2 && c == 8'hC0) pat = 8'hFF;
        if (ix == 1 && c == 8'hC0 && d == 8'hC0) pat = 8'hFF;
`endif
        a     = 3'b111;
        a[ix] = 1'b0;
        return {tk, a, pat};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s t=%0d: got tick=%b an=%b seg=%h, expected tick=%b an=%b seg=%h",
                         name, t, act[11], act[10:8], act[7:0], exp[11], exp[10:8], exp[7:0]);
        end
    endtask

    always @(negedge clk) begin
        if (t >= 0) begin
            check("model_blank2", {tk0, an0, seg0}, model(t, BLANK, m_u, m_d, m_c));
            check("model_blank0", {tk1, an1, seg1}, model(t, 0, m_u, m_d, m_c));
        end
    end

    // Advance to 1 time unit after the edge that displays position p.
    task automatic goto_p(input int p);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (t != p + 1 && n < 200);
        if (t != p + 1) begin
            checks++;
            failures++;
            $display("FAIL goto_p: position %0d not reached, t=%0d", p, t);
        end
    endtask

    function automatic logic [7:0] rand_pat();
        return ($urandom_range(0, 1) == 0) ? 8'hC0 : 8'($urandom);
    endfunction

    initial begin
        su = 8'hF9; sd = 8'hA4; sc = 8'hB0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dut0", {tk0, an0, seg0}, {1'b0, 3'b111, 8'hFF});
        check("reset_dut1", {tk1, an1, seg1}, {1'b0, 3'b111, 8'hFF});
        rst = 1'b0;

        goto_p(0);
        check("first_tick_dut0", {tk0, an0, seg0}, {1'b1, 3'b111, 8'hFF});
        check("first_tick_dut1", {tk1, an1, seg1}, {1'b1, 3'b110, 8'hFF});
        goto_p(2);
        check("frame0_blank", {tk0, an0, seg0}, {1'b0, 3'b110, 8'hFF});
        goto_p(24);
        check("tick_frame1", {tk0, an0, seg0}, {1'b1, 3'b111, 8'hFF});
        check("tick_frame1_b0", {tk1, an1, seg1}, {1'b1, 3'b110, 8'hF9});
        goto_p(26);
        check("scan_units", {tk0, an0, seg0}, {1'b0, 3'b110, 8'hF9});
        goto_p(34);
        check("scan_tens", {tk0, an0, seg0}, {1'b0, 3'b101, 8'hA4});
        goto_p(45);
        check("scan_hundreds", {tk0, an0, seg0}, {1'b0, 3'b011, 8'hB0});
        goto_p(48);
        check("tick_frame2", {tk0, an0, seg0}, {1'b1, 3'b111, 8'hFF});

        goto_p(50);
        su = 8'h92; sd = 8'h99;
        goto_p(58);
        check("no_tear_tens", {tk0, an0, seg0}, {1'b0, 3'b101, 8'hA4});
        goto_p(74);
        check("next_frame_units", {tk0, an0, seg0}, {1'b0, 3'b110, 8'h92});
        goto_p(82);
        check("next_frame_tens", {tk0, an0, seg0}, {1'b0, 3'b101, 8'h99});

        goto_p(85);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midscan_reset", {tk0, an0, seg0}, {1'b0, 3'b111, 8'hFF});
        rst = 1'b0;
        goto_p(2);
        check("post_reset_blank_u", {tk0, an0, seg0}, {1'b0, 3'b110, 8'hFF});
        goto_p(10);
        check("post_reset_blank_d", {tk0, an0, seg0}, {1'b0, 3'b101, 8'hFF});

        goto_p(20);
        su = 8'hF9; sd = 8'hC0; sc = 8'hC0;
        goto_p(26);
        check("lzb_units", {tk0, an0, seg0}, {1'b0, 3'b110, 8'hF9});
        goto_p(34);
`ifdef SEVEN_SEG_SCAN_LZB_EN
        check("lzb_tens", {tk0, an0, seg0}, {1'b0, 3'b101, 8'hFF});
`else
        check("zero_tens", {tk0, an0, seg0}, {1'b0, 3'b101, 8'hC0});
`endif
        goto_p(42);
`ifdef SEVEN_SEG_SCAN_LZB_EN
        check("lzb_hundreds", {tk0, an0, seg0}, {1'b0, 3'b011, 8'hFF});
`else
        check("zero_hundreds", {tk0, an0, seg0}, {1'b0, 3'b011, 8'hC0});
`endif
        goto_p(44);
        sc = 8'hF9;
        goto_p(58);
        check("inner_zero_tens", {tk0, an0, seg0}, {1'b0, 3'b101, 8'hC0});
        goto_p(66);
        check("nonzero_hundreds", {tk0, an0, seg0}, {1'b0, 3'b011, 8'hF9});

        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 14) == 0) su = rand_pat();
            if ($urandom_range(0, 14) == 0) sd = rand_pat();
            if ($urandom_range(0, 14) == 0) sc = rand_pat();
            rst = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0;
        repeat (2 * FRAME) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seven_seg_scan.md
# seven_seg_scan

Time-multiplexed driver for the three-digit common-anode 7-segment display. It consumes the three active-low segment patterns (units, tens, hundreds) produced by the frequency display encoder. It drives one shared segment bus plus three active-low anode enables, scanning one digit per slot with a blanking gap against ghosting. Patterns are snapshotted once per frame so a frequency change never tears mid-frame.

## Interface
Parameters:
- `DIV`, 50000: clock cycles per digit slot; legal range ≥ 2.
- `BLANK`, 500: cycles at the start of each slot with all anodes off; legal range 0 ≤ BLANK < DIV.

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  synchronous, active-high reset.
- `Seg_U`  in  8  units pattern; active-low, bit7 = dp.
- `Seg_D`  in  8  tens pattern; same encoding.
- `Seg_C`  in  8  hundreds pattern; same encoding.
- `seg`  out  8  shared segment bus, active-low.
- `an`  out  3  anode enables, active-low; an[0] = units, an[1] = tens, an[2] = hundreds.
- `frame_tick`  out  1  one-cycle pulse in the first cycle of each frame.

## Operation
- State registers:
  - slot counter `cnt`, range 0..DIV-1, width $clog2(DIV).
  - digit index `idx`, range 0..2, order 0 = U, 1 = D, 2 = C.
  - three 8-bit shadow registers `sh_U`, `sh_D`, `sh_C`.
- `cnt` increments every cycle. On `cnt == DIV-1` it wraps to 0 and `idx` advances; `idx` wraps from 2 to 0.
- Shadow load: on the edge where `cnt == DIV-1` and `idx == 2`, the shadows capture `Seg_U`, `Seg_D` and `Seg_C`. That snapshot holds for the whole following frame. Inputs are ignored at all other times.
- Per-slot phases, with the state machine implied by `cnt`:
  - BLANK phase, `cnt < BLANK`: `an = 3'b111`, `seg = 8'hFF`.
  - SHOW phase, `cnt ≥ BLANK`: `an` has only bit `idx` low; `seg = sh[idx]`.
- With `BLANK == 0` the BLANK phase never occurs.
- `frame_tick` is 1 exactly when `idx == 0` and `cnt == 0`.
- Reset values (rst sampled high):
  - `cnt = 0`, `idx = 0`.
  - shadows = 8'hFF.
  - `seg = 8'hFF`, `an = 3'b111`, `frame_tick = 0`.
- Reset mid-frame: the scan aborts immediately and the next cycle shows the reset values.
- First frame after reset: shows blank segments from the 8'hFF shadows. The first real data appears in the second frame.
- Simultaneous input change and shadow-load edge: the value present at that edge is captured.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Outputs in a given cycle reflect that cycle's `cnt`/`idx`. The registers are computed from next-state values.
- `frame_tick` first asserts in the first cycle after `rst` deasserts. It repeats every 3·DIV cycles.
- Input-to-display latency: a pattern present at the load edge is visible from SHOW of slot 0 of the next frame. Worst case is ≤ 6·DIV cycles after an input change.
- In each slot `an` is active for exactly DIV-BLANK cycles. No two anodes are ever low in the same cycle.

## Configuration
- Macro: `SEVEN_SEG_SCAN_LZB_EN`, leading-zero blanking.
- When defined:
  - If `sh_C == 8'hC0` (digit 0, dp off), the hundreds slot shows `seg = 8'hFF` with `an[2]` still driven.
  - If the hundreds slot is blanked and `sh_D == 8'hC0`, the tens slot is blanked the same way.
  - Units are never blanked.
  - The blanking decision uses the shadows, so it is frame-coherent.
- When undefined: every slot shows its shadow pattern unchanged. There is no comparison logic.

## Structure
- Shared package `seg_pkg`:
  - `SEG_OFF = 8'hFF`, `SEG_ZERO = 8'hC0`, `AN_OFF = 3'b111`.
  - `digit_idx_t`, a 2-bit enum with values DIG_U, DIG_D, DIG_C.
- One natural sub-module, `seg_slot_timer`, parameterized by DIV/BLANK:
  - outputs: `cnt`, `idx`, a `show` flag, `frame_tick`, and a `load` strobe.
- `seven_seg_scan` owns the shadows, the LZB logic and the output registers.

## Test plan
All scenarios use DIV=8, BLANK=2 (frame = 24 cycles).
- Reset: hold `rst` 3 cycles → `seg = FF`, `an = 111`, `frame_tick = 0`. After release `frame_tick` pulses at cycle 0 and every 24 cycles thereafter.
- Scan order: inputs U=F9 ("1"), D=A4 ("2"), C=B0 ("3"), second frame observed:
  - slot 0: cycles 0–1 `an = 111`, cycles 2–7 `an = 110`, `seg = F9`.
  - slot 1: `an = 101`, `seg = A4`.
  - slot 2: `an = 011`, `seg = B0`.
- Tearing: change U from F9 to 92 mid-frame (cycle 10) → the current frame keeps F9. The next frame shows 92.
- Reset mid-scan: assert `rst` at `idx = 1`, `cnt = 5` → next cycle `seg = FF`, `an = 111`. The following frame is blank.
- BLANK = 0 variant: `an` is never 111 after the first frame. No overlap between anodes.
- LZB (macro defined), C=C0, D=C0, U=F9 → `an[2]` and `an[1]` slots drive `seg = FF`; units slot shows F9. With C=F9, D=C0 → the tens slot shows C0.
